axi_req_responder: RTL and testbench
====================================

Name: axi_req_responder

Overview:
- Completion end of the {id, addr, data} valid/ready request channel carried by the full register slice.
- Accepts one request per cycle, executes a word write or read against a local register array, and returns an ID-tagged response through an internal response FIFO.
- The response FIFO absorbs downstream backpressure.
- Serves as the target/sink for slice and FIFO integration tests and as a simple memory-mapped scratch target.

Parameters:
ID_WIDTH, 3, request/response tag width
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, data word width (byte addresses, word-aligned, 4 bytes/word)
MEM_DEPTH, 16, number of words in the register array (power of 2, >=2)
RSP_DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request valid
req_ready_o  out  1  request ready
req_we_i  in  1  1 = write, 0 = read; qualified by req_valid_i
req_data_i  in  ID_WIDTH+ADDR_WIDTH+DATA_WIDTH  packed {id, addr, wdata}, id in MSBs
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_data_o  out  ID_WIDTH+DATA_WIDTH+2  packed {id, rdata, resp}, resp in LSBs

Behaviour:
- Reset (rstn=1, asynchronous):
  - FIFO pointers and count cleared; array cleared to 0.
  - rsp_valid_o=0, rsp_data_o=0, req_ready_o=0 while in reset.
  - req_ready_o=1 from the first clock edge after release.
- Request acceptance:
  - A request is accepted on a rising edge where req_valid_i and req_ready_o are both 1.
  - req_ready_o = (count < RSP_DEPTH), registered or derived from registered count only. There is no combinational path from rsp_ready_i to req_ready_o.
  - When full, req_ready_o=0 even if a pop occurs in the same cycle.
- Address decode:
  - idx = addr[2 +: log2(MEM_DEPTH)].
  - Error if addr[1:0]!=0, or if any addr bit above the idx field is nonzero.
- Execution (at the acceptance edge):
  - Write OK: mem[idx] <= wdata; response {id, 0, OKAY}.
  - Read OK: response {id, mem[idx], OKAY}.
  - Error: array unchanged; response {id, 0, SLVERR}.
  - resp encoding: OKAY=2'b00, SLVERR=2'b10.
- Ordering: responses are returned strictly in acceptance order. A read accepted one cycle after a write to the same idx returns the new data.
- Latency: request accepted at edge N -> response visible on rsp_valid_o after edge N (first cycle following acceptance) when the FIFO was empty. No same-cycle bypass.
- Response channel:
  - rsp_valid_o = (count != 0); rsp_data_o = head entry.
  - Entry popped on an edge with rsp_valid_o & rsp_ready_i.
  - rsp_data_o holds stable while rsp_valid_o=1 and rsp_ready_i=0.
  - When empty, rsp_data_o holds the last value (0 after reset).
- Simultaneous push and pop: count unchanged, both pointers advance, with wrap-around modulo RSP_DEPTH.
- Reset mid-operation: all in-flight responses are discarded; no response is emitted for requests accepted before reset.
- req_data_i and req_we_i are don't-care (may be X) when req_valid_i=0. X on these inputs must not corrupt state.

Optional Feature:
- Macro: AXI_REQ_RESPONDER_STATS_EN.
- When defined, adds two outputs:
  - req_cnt_o [15:0]: count of accepted requests.
  - err_cnt_o [15:0]: count of SLVERR responses generated.
  - Both are saturating at 16'hFFFF and cleared by rstn.
- When undefined, neither port nor counter logic exists, and the rest of the behaviour is identical.

Decomposition:
- Package axi_req_pkg:
  - ID_WIDTH, ADDR_WIDTH and DATA_WIDTH defaults.
  - resp_t enum (OKAY, SLVERR).
  - Packed structs req_t {id, addr, wdata} and rsp_t {id, rdata, resp}.
- Sub-module rsp_fifo: synchronous FIFO parameterised on width and depth, exposing full, empty and count. The top level instantiates it once.
- Decode, array and stats logic stay in the top level.

Test Plan:
- Write id=1, addr=0x8, wdata=0xA5A5A5A5 with rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o={1, 0, 2'b00}.
- Back-to-back: write addr=0x4 data=7, then read addr=0x4 with id=2 in consecutive cycles -> responses in order; second is {2, 7, OKAY}.
- Errors: read addr=0x2 and write addr=0x40 (MEM_DEPTH=16) -> both SLVERR, rdata=0; a later read of 0x0 returns 0 (array untouched).
- Backpressure: rsp_ready_i=0 with 5 requests offered -> 4 accepted, then req_ready_o=0; rsp_data_o stable. Set rsp_ready_i=1 -> 4 responses drain in order, and the 5th is accepted one cycle after the first pop.
- Full with simultaneous pop: count=4 and rsp_ready_i=1 -> req_ready_o still 0 that cycle; count goes to 3 and req_ready_o rises on the next cycle.
- Reset with 3 responses pending -> rsp_valid_o=0 immediately (asynchronous), array reads back 0, and no stale responses after release. With AXI_REQ_RESPONDER_STATS_EN, req_cnt_o and err_cnt_o read 0 after reset and match the counts from the scenarios above.

Source files
------------

// File: rtl/axi_req_pkg.sv
// Shared types for the {id, addr, data} request channel and its ID-tagged response.
package axi_req_pkg;

    localparam int unsigned DEF_ID_WIDTH   = 3;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_ADDR_WIDTH-1:0] addr;
        logic [DEF_DATA_WIDTH-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] rdata;
        resp_t                     resp;
    } rsp_t;

endpackage

// File: rtl/axi_req_responder_rsp_fifo.sv
// Response FIFO: power-of-two depth, registered head/full/empty/count.
// The head register holds its last value once the FIFO drains.
module rsp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    i_push,
    input  logic [WIDTH-1:0]        i_din,
    input  logic                    i_pop,
    output logic [WIDTH-1:0]        o_dout,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             r_full;
    logic             r_empty;
    logic [WIDTH-1:0] r_dout;
    logic [WIDTH-1:0] w_head_next;
    logic             w_push;
    logic             w_pop;

    assign w_push = i_push & ~r_full;
    assign w_pop  = i_pop & ~r_empty;

    // Next read pointer, occupancy and head word (bypass when the new entry becomes head)
    always_comb begin
        w_rd_ptr_next = r_rd_ptr;
        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        end
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_head_next  = r_mem[w_rd_ptr_next];
        if (w_push && (r_wr_ptr == w_rd_ptr_next)) begin
            w_head_next = i_din;
        end
    end

    // Storage write; contents need no reset because only counted entries are ever shown
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers, flags and registered head
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_dout   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_W'(DEPTH));
            r_empty  <= (w_count_next == '0);
            if (w_count_next != '0) begin
                r_dout <= w_head_next;
            end
        end
    end

    assign o_dout  = r_dout;
    assign o_full  = r_full;
    assign o_empty = r_empty;
    assign o_count = r_count;

endmodule

// File: rtl/axi_req_responder.sv
// Request-channel completer: word read/write against a local register array,
// ID-tagged responses returned in order through a response FIFO.
// rstn is an asynchronous reset asserted high.
// Optional AXI_REQ_RESPONDER_STATS_EN adds saturating request/error counters.
module axi_req_responder
    import axi_req_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH  = 16,
    parameter int unsigned RSP_DEPTH  = 4
) (
    input  logic                                     clk,
    input  logic                                     rstn,
    input  logic                                     req_valid_i,
    output logic                                     req_ready_o,
    input  logic                                     req_we_i,
    input  logic [ID_WIDTH+ADDR_WIDTH+DATA_WIDTH-1:0] req_data_i,
    output logic                                     rsp_valid_o,
    input  logic                                     rsp_ready_i,
    output logic [ID_WIDTH+DATA_WIDTH+1:0]           rsp_data_o
`ifdef AXI_REQ_RESPONDER_STATS_EN
    ,
    output logic [15:0]                              req_cnt_o,
    output logic [15:0]                              err_cnt_o
`endif
);

    localparam int unsigned REQ_W = ID_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int unsigned RSP_W = ID_WIDTH + DATA_WIDTH + 2;
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned CNT_W = $clog2(RSP_DEPTH) + 1;

    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_err;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_rdata;
    resp_t                 w_resp;
    logic [RSP_W-1:0]      w_rsp_din;
    logic                  w_full;
    logic                  w_empty;
    logic [CNT_W-1:0]      w_count;
    logic                  w_unused;
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    // Request unpacking and address decode
    assign w_id    = req_data_i[REQ_W-1 -: ID_WIDTH];
    assign w_addr  = req_data_i[DATA_WIDTH +: ADDR_WIDTH];
    assign w_wdata = req_data_i[DATA_WIDTH-1:0];
    assign w_idx   = w_addr[2 +: IDX_W];
    assign w_err   = (w_addr[1:0] != 2'b00) || ((w_addr >> (IDX_W + 2)) != '0);

    // Ready depends only on registered state, never on rsp_ready_i
    assign req_ready_o = r_live & ~w_full;
    assign rsp_valid_o = ~w_empty;
    assign w_push      = req_valid_i & req_ready_o;

    // Response payload built at the acceptance edge
    assign w_rdata   = (!req_we_i && !w_err) ? r_mem[w_idx] : '0;
    assign w_resp    = w_err ? SLVERR : OKAY;
    assign w_rsp_din = {w_id, w_rdata, w_resp};

    // Occupancy is kept on the FIFO interface for debug visibility only
    assign w_unused = ^w_count;

    // Ready is held low in reset and rises on the first edge after release
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Register array; only accepted, error-free writes modify it
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && req_we_i && !w_err) begin
            r_mem[w_idx] <= w_wdata;
        end
    end

    rsp_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_din   (w_rsp_din),
        .i_pop   (rsp_ready_i),
        .o_dout  (rsp_data_o),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

`ifdef AXI_REQ_RESPONDER_STATS_EN
    logic [15:0] r_req_cnt;
    logic [15:0] r_err_cnt;

    // Saturating counters of accepted requests and SLVERR responses
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_req_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_push) begin
            if (r_req_cnt != 16'hFFFF) begin
                r_req_cnt <= r_req_cnt + 16'd1;
            end
            if (w_err && (r_err_cnt != 16'hFFFF)) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign req_cnt_o = r_req_cnt;
    assign err_cnt_o = r_err_cnt;
`endif

endmodule

// File: tb/tb_axi_req_responder.sv
// Bench for axi_req_responder: directed scenarios plus randomized traffic,
// checked against a queue/array reference model.
module tb_axi_req_responder;
    import axi_req_pkg::*;

    localparam int MEM_DEPTH = 16;
    localparam int RSP_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic        req_we_i = 1'b0;
    logic [66:0] req_data_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [36:0] rsp_data_o;
`ifdef AXI_REQ_RESPONDER_STATS_EN
    logic [15:0] req_cnt_o;
    logic [15:0] err_cnt_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    axi_req_responder #(
        .ID_WIDTH   (3),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (MEM_DEPTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_data_i  (req_data_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o)
`ifdef AXI_REQ_RESPONDER_STATS_EN
        ,
        .req_cnt_o   (req_cnt_o),
        .err_cnt_o   (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: expected responses in a queue, scratch words in an array
    rsp_t        m_q[$];
    logic [31:0] m_mem [MEM_DEPTH];
    bit          m_live = 1'b0;
    rsp_t        m_last = '0;
    int          m_req_cnt = 0;
    int          m_err_cnt = 0;
    bit          m_acc = 1'b0;
    bit          m_pop;
    bit          m_bad;
    req_t        m_rq;
    rsp_t        m_r;

    always @(posedge clk or posedge rstn) begin
        if (rstn) begin
            m_q.delete();
            foreach (m_mem[i]) m_mem[i] = '0;
            m_live    = 1'b0;
            m_last    = '0;
            m_req_cnt = 0;
            m_err_cnt = 0;
            m_acc     = 1'b0;
        end else begin
            m_acc = req_valid_i && m_live && (m_q.size() < RSP_DEPTH);
            m_pop = (m_q.size() != 0) && rsp_ready_i;
            if (m_acc) begin
                m_rq    = req_t'(req_data_i);
                m_bad   = (m_rq.addr % 4 != 0) || (m_rq.addr >= 32'(MEM_DEPTH * 4));
                m_r.id    = m_rq.id;
                m_r.rdata = '0;
                m_r.resp  = m_bad ? SLVERR : OKAY;
                if (!m_bad) begin
                    if (req_we_i) m_mem[m_rq.addr / 4] = m_rq.wdata;
                    else          m_r.rdata = m_mem[m_rq.addr / 4];
                end
                if (m_req_cnt < 65535) m_req_cnt++;
                if (m_bad && m_err_cnt < 65535) m_err_cnt++;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_acc) m_q.push_back(m_r);
            if (m_q.size() != 0) m_last = m_q[0];
            m_live = 1'b1;
        end
    end

    function automatic bit exp_ready();
        return m_live && (m_q.size() < RSP_DEPTH);
    endfunction

    function automatic bit exp_valid();
        return m_q.size() != 0;
    endfunction

    function automatic rsp_t mk_rsp(input logic [2:0] id, input logic [31:0] rd, input resp_t rs);
        rsp_t r;
        r.id    = id;
        r.rdata = rd;
        r.resp  = rs;
        return r;
    endfunction

    task automatic drive(input bit v, input bit we, input logic [2:0] id,
                         input logic [31:0] addr, input logic [31:0] wd, input bit rr);
        req_valid_i = v;
        req_we_i    = we;
        req_data_i  = {id, addr, wd};
        rsp_ready_i = rr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (req_ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready_o);
        else n_pass++;
        n_total++;
        if (rsp_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", rsp_valid_o);
        else n_pass++;
        n_total++;
        if (rsp_data_o !== 37'd0) $display("FAIL reset_data: got %h want 0", rsp_data_o);
        else n_pass++;
        @(negedge clk);
        rstn = 1'b0;
        tick();
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL ready_after_release: got %b want 1", req_ready_o);
        else n_pass++;
`ifdef AXI_REQ_RESPONDER_STATS_EN
        n_total++;
        if ({req_cnt_o, err_cnt_o} !== 32'd0) $display("FAIL reset_stats: got %h want 0", {req_cnt_o, err_cnt_o});
        else n_pass++;
`endif
    endtask

    task automatic test_write_first();
        rsp_t e;
        drive(1'b1, 1'b1, 3'd1, 32'h8, 32'hA5A5A5A5, 1'b1);
        tick();
        e = mk_rsp(3'd1, 32'd0, OKAY);
        n_total++;
        if (rsp_valid_o !== 1'b1) $display("FAIL write_valid: got %b want 1", rsp_valid_o);
        else n_pass++;
        n_total++;
        if (rsp_data_o !== e) $display("FAIL write_rsp: got %h want %h", rsp_data_o, e);
        else n_pass++;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        tick();
        n_total++;
        if (rsp_valid_o !== 1'b0) $display("FAIL write_drained: got %b want 0", rsp_valid_o);
        else n_pass++;
        n_total++;
        if (rsp_data_o !== e) $display("FAIL empty_hold: got %h want %h", rsp_data_o, e);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        drive(1'b1, 1'b1, 3'd3, 32'h4, 32'd7, 1'b1);
        tick();
        e = mk_rsp(3'd3, 32'd0, OKAY);
        n_total++;
        if (rsp_data_o !== e) $display("FAIL b2b_write_rsp: got %h want %h", rsp_data_o, e);
        else n_pass++;
        drive(1'b1, 1'b0, 3'd2, 32'h4, 32'hDEAD0000, 1'b1);
        tick();
        e = mk_rsp(3'd2, 32'd7, OKAY);
        n_total++;
        if (rsp_data_o !== e || rsp_valid_o !== 1'b1) $display("FAIL b2b_read_rsp: got %b/%h want 1/%h", rsp_valid_o, rsp_data_o, e);
        else n_pass++;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_errors();
        rsp_t e;
        drive(1'b1, 1'b0, 3'd4, 32'h2, 32'd0, 1'b1);
        tick();
        e = mk_rsp(3'd4, 32'd0, SLVERR);
        n_total++;
        if (rsp_data_o !== e) $display("FAIL err_misaligned: got %h want %h", rsp_data_o, e);
        else n_pass++;
        drive(1'b1, 1'b1, 3'd5, 32'h40, 32'hFFFF_FFFF, 1'b1);
        tick();
        e = mk_rsp(3'd5, 32'd0, SLVERR);
        n_total++;
        if (rsp_data_o !== e) $display("FAIL err_range: got %h want %h", rsp_data_o, e);
        else n_pass++;
        drive(1'b1, 1'b0, 3'd6, 32'h0, 32'd0, 1'b1);
        tick();
        e = mk_rsp(3'd6, 32'd0, OKAY);
        n_total++;
        if (rsp_data_o !== e) $display("FAIL err_untouched: got %h want %h", rsp_data_o, e);
        else n_pass++;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_backpressure();
        int   k = 0;
        rsp_t e;
        for (int c = 0; c < 7; c++) begin
            drive(1'b1, 1'b1, 3'(k + 1), 32'(16 + 4 * k), 32'($urandom()), 1'b0);
            tick();
            if (m_acc) k++;
            n_total++;
            if (req_ready_o !== exp_ready()) $display("FAIL bp_ready c%0d: got %b want %b", c, req_ready_o, exp_ready());
            else n_pass++;
            n_total++;
            if (rsp_data_o !== m_last) $display("FAIL bp_stable c%0d: got %h want %h", c, rsp_data_o, m_last);
            else n_pass++;
        end
        e = mk_rsp(3'd1, 32'd0, OKAY);
        n_total++;
        if (req_ready_o !== 1'b0 || rsp_data_o !== e) $display("FAIL bp_full: got %b/%h want 0/%h", req_ready_o, rsp_data_o, e);
        else n_pass++;
        // First pop while full: ready may only rise after this edge
        drive(1'b1, 1'b1, 3'(k + 1), 32'(16 + 4 * k), 32'h5555_0005, 1'b1);
        tick();
        n_total++;
        if (req_ready_o !== 1'b1) $display("FAIL bp_ready_rise: got %b want 1", req_ready_o);
        else n_pass++;
        for (int c = 0; c < 8; c++) begin
            if (m_acc) drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
            tick();
            n_total++;
            if (rsp_valid_o !== exp_valid() || rsp_data_o !== m_last || req_ready_o !== exp_ready())
                $display("FAIL bp_drain c%0d: got %b/%h/%b want %b/%h/%b", c, rsp_valid_o, rsp_data_o,
                         req_ready_o, exp_valid(), m_last, exp_ready());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 9))
                0:       addr = $urandom();
                1:       addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            drive(($urandom_range(0, 9) < 7), 1'($urandom()), 3'($urandom()), addr, $urandom(),
                  ($urandom_range(0, 9) < 6));
            tick();
            n_total++;
            if (req_ready_o !== exp_ready()) $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready_o, exp_ready());
            else n_pass++;
            n_total++;
            if (rsp_valid_o !== exp_valid()) $display("FAIL rnd_valid c%0d: got %b want %b", c, rsp_valid_o, exp_valid());
            else n_pass++;
            n_total++;
            if (rsp_data_o !== m_last) $display("FAIL rnd_data c%0d: got %h want %h", c, rsp_data_o, m_last);
            else n_pass++;
        end
`ifdef AXI_REQ_RESPONDER_STATS_EN
        n_total++;
        if (req_cnt_o !== 16'(m_req_cnt)) $display("FAIL stats_req: got %0d want %0d", req_cnt_o, m_req_cnt);
        else n_pass++;
        n_total++;
        if (err_cnt_o !== 16'(m_err_cnt)) $display("FAIL stats_err: got %0d want %0d", err_cnt_o, m_err_cnt);
        else n_pass++;
`endif
    endtask

    task automatic test_reset_mid();
        int k = 0;
        for (int c = 0; c < 6 && k < 3; c++) begin
            drive(1'b1, 1'b1, 3'(k + 1), 32'(4 * (k + 1)), 32'h1000 + 32'(k), 1'b0);
            tick();
            if (m_acc) k++;
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        n_total++;
        if (rsp_valid_o !== 1'b1) $display("FAIL mid_pending: got %b want 1", rsp_valid_o);
        else n_pass++;
        #2;
        rstn = 1'b1;
        #1;
        n_total++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) $display("FAIL mid_async: got %b/%b want 0/0", rsp_valid_o, req_ready_o);
        else n_pass++;
`ifdef AXI_REQ_RESPONDER_STATS_EN
        n_total++;
        if ({req_cnt_o, err_cnt_o} !== 32'd0) $display("FAIL mid_stats: got %h want 0", {req_cnt_o, err_cnt_o});
        else n_pass++;
`endif
        @(negedge clk);
        rstn = 1'b0;
        tick();
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 1'b0, 3'(c), 32'(4 * c), 32'd0, 1'b1);
            tick();
            n_total++;
            if (rsp_data_o !== mk_rsp(3'(c), 32'd0, OKAY) || rsp_data_o !== m_last)
                $display("FAIL mid_readback c%0d: got %h want %h", c, rsp_data_o, m_last);
            else n_pass++;
        end
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_total++;
            if (rsp_valid_o !== exp_valid()) $display("FAIL mid_no_stale c%0d: got %b want %b", c, rsp_valid_o, exp_valid());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_write_first();
        test_back_to_back();
        test_errors();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
